// File: rtl/fb_draw_pkg.sv
// Shared constants, FSM state encoding and the round-robin
// winner search for the framebuffer draw arbiter.
package fb_draw_pkg;

  localparam int H_RES = 320;
  localparam int V_RES = 240;
  localparam int X_W   = 9;
  localparam int Y_W   = 8;
  localparam int C_W   = 3;

  localparam int MAX_CLIENTS = 8;
  localparam int IDX_W       = 4;

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } drawState_t;

  // First set bit of elig at or after ptr, wrapping at n.
  function automatic logic rrSearch(
    input  logic [MAX_CLIENTS-1:0] elig,
    input  logic [IDX_W-1:0]       ptr,
    input  int                     n,
    output logic [IDX_W-1:0]       win
  );
    logic           found;
    logic [IDX_W:0] cand;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < MAX_CLIENTS; i++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(n))
        cand = cand - (IDX_W+1)'(n);
      if (!found && i < n && elig[cand[IDX_W-2:0]]) begin
        found = 1'b1;
        win   = cand[IDX_W-1:0];
      end
    end
    return found;
  endfunction

endpackage

// File: rtl/fb_clear_scan.sv
// Row-major x/y scan counter over an H_RES x V_RES area.
// start loads (0,0); enable steps one pixel; last flags the final pixel.
module fb_clear_scan #(
  parameter int H_RES = 320,
  parameter int V_RES = 240,
  parameter int X_W   = 9,
  parameter int Y_W   = 8
) (
  input  logic           clock,
  input  logic           resetn,
  input  logic           start,
  input  logic           enable,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);

  localparam logic [X_W-1:0] X_END = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_END = Y_W'(V_RES - 1);

  logic xWrap;
  logic yWrap;

  assign xWrap = (x == X_END);
  assign yWrap = (y == Y_END);
  assign last  = xWrap && yWrap;

  // Scan position: restart on start, step row-major on enable.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      x <= '0;
      y <= '0;
    end else if (start) begin
      x <= '0;
      y <= '0;
    end else if (enable) begin
      if (xWrap) begin
        x <= '0;
        y <= yWrap ? '0 : y + Y_W'(1);
      end else begin
        x <= x + X_W'(1);
      end
    end
  end

endmodule

// File: rtl/fb_draw_arbiter.sv
// Round-robin arbiter sharing the framebuffer write port between
// pixel producers, with a full-screen clear that pre-empts them.
module fb_draw_arbiter #(
  parameter int N_CLIENTS = 3,
  parameter int X_W       = 9,
  parameter int Y_W       = 8,
  parameter int C_W       = 3,
  parameter int H_RES     = 320,
  parameter int V_RES     = 240,
  parameter logic [C_W-1:0] CLEAR_COLOUR = '0
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic [N_CLIENTS-1:0]     req,
  input  logic [N_CLIENTS*X_W-1:0] x_in,
  input  logic [N_CLIENTS*Y_W-1:0] y_in,
  input  logic [N_CLIENTS*C_W-1:0] colour_in,
  output logic [N_CLIENTS-1:0]     ack,
  input  logic                     clear_start,
  output logic                     busy,
  output logic                     plot,
  output logic [X_W-1:0]           x,
  output logic [Y_W-1:0]           y,
  output logic [C_W-1:0]           colour,
  output logic                     oob
);

  import fb_draw_pkg::*;

  localparam logic [0:0] ST_ARB   = ARB;
  localparam logic [0:0] ST_CLEAR = CLEAR;

  localparam logic [X_W-1:0] H_LIM = X_W'(H_RES);
  localparam logic [Y_W-1:0] V_LIM = Y_W'(V_RES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLIENTS - 1);

  logic [0:0]           state;
  logic [IDX_W-1:0]     rrPtr;
  logic [N_CLIENTS-1:0] ackR;
  logic                 plotR;
  logic                 oobR;
  logic [X_W-1:0]       xR;
  logic [Y_W-1:0]       yR;
  logic [C_W-1:0]       colourR;

  logic [MAX_CLIENTS-1:0] elig;
  logic                   found;
  logic [IDX_W-1:0]       winIdx;
  logic [IDX_W-1:0]       ptrNext;
  logic [N_CLIENTS-1:0]   winOneHot;
  logic [X_W-1:0]         xSel;
  logic [Y_W-1:0]         ySel;
  logic [C_W-1:0]         cSel;
  logic                   inRange;
  logic                   inArb;
  logic                   clearing;
  logic                   startClr;
  logic                   grant;

  logic [X_W-1:0] scanX;
  logic [Y_W-1:0] scanY;
  logic           scanLast;

  assign inArb    = (state == ST_ARB);
  assign clearing = (state == ST_CLEAR);
  assign startClr = inArb && clear_start;

  // Winner search and selection of the winning client's pixel.
  always_comb begin
    elig = '0;
    elig[N_CLIENTS-1:0] = req & ~ackR;
    winIdx  = '0;
    found   = rrSearch(elig, rrPtr, N_CLIENTS, winIdx);
    grant   = inArb && !clear_start && found;
    ptrNext = (winIdx == LAST_IDX) ? '0 : winIdx + IDX_W'(1);
    winOneHot = N_CLIENTS'(1) << winIdx;
    xSel = X_W'(x_in >> (int'(winIdx) * X_W));
    ySel = Y_W'(y_in >> (int'(winIdx) * Y_W));
    cSel = C_W'(colour_in >> (int'(winIdx) * C_W));
    inRange = (xSel < H_LIM) && (ySel < V_LIM);
  end

  fb_clear_scan #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .X_W   (X_W),
    .Y_W   (Y_W)
  ) uScan (
    .clock  (clock),
    .resetn (resetn),
    .start  (startClr),
    .enable (clearing),
    .x      (scanX),
    .y      (scanY),
    .last   (scanLast)
  );

  // Mode FSM and round-robin pointer; the pointer survives a clear.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= ST_ARB;
      rrPtr <= '0;
    end else begin
      unique case (1'b1)
        inArb: begin
          if (clear_start)
            state <= ST_CLEAR;
          else if (found)
            rrPtr <= ptrNext;
        end
        clearing: begin
          if (scanLast)
            state <= ST_ARB;
        end
        default: state <= ST_ARB;
      endcase
    end
  end

  // Registered grant outputs: ack pulse, plot or oob, pixel data.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ackR    <= '0;
      plotR   <= 1'b0;
      oobR    <= 1'b0;
      xR      <= '0;
      yR      <= '0;
      colourR <= '0;
    end else begin
      ackR  <= grant ? winOneHot : '0;
      plotR <= grant && inRange;
      oobR  <= grant && !inRange;
      if (grant) begin
        xR      <= xSel;
        yR      <= ySel;
        colourR <= cSel;
      end
    end
  end

  assign ack    = ackR;
  assign oob    = oobR;
  assign busy   = clearing;
  assign plot   = clearing | plotR;
  assign x      = clearing ? scanX : xR;
  assign y      = clearing ? scanY : yR;
  assign colour = clearing ? CLEAR_COLOUR : colourR;

endmodule
